// File: rtl/inc_seq_pkg.sv
// Shared types and constants for the nibble-serial incrementer.
// Holds the FSM state encoding, the nibble width, the counter width and a saturating-increment helper.
package inc_seq_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int OVF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (&v) ? v : v + OVF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/nibble_incrementer.sv
// Combinational 4-bit ripple incrementer built from full-adder cells with B tied low.
// Zero latency. No flow control: output follows input.
module nibble_incrementer
  import inc_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] b;
  logic [NIBBLE_W:0]   c;

  assign b    = '0;
  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/inc_nibble_sequencer.sv
// Walks a W-bit operand one nibble per cycle through one 4-bit incrementer; latency NIBBLES cycles (fewer with INC_EARLY_EXIT_EN).
// The result is held in HOLD until out_ready, and no new operand is taken meanwhile.
module inc_nibble_sequencer
  import inc_seq_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   in_data,
  input  logic                          in_inc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   out_data,
  output logic                          out_cout,
  output logic                          busy,
  output logic [OVF_CNT_W-1:0]          ovf_count
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_t                            state;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]  operand_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]  result_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]  result_nxt;
  logic [IDX_W-1:0]                  idx;
  logic                              carry;
  logic [NIBBLE_W-1:0]               nib_sum;
  logic                              nib_cout;
  logic                              done;

  nibble_incrementer u_inc (
    .a    (operand_q[idx]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

`ifdef INC_EARLY_EXIT_EN
  // Once the carry dies the remaining nibbles cannot change, so finish now.
  assign done = (idx == LAST) || !nib_cout;
`else
  assign done = (idx == LAST);
`endif

  always_comb begin
    result_nxt      = result_q;
    result_nxt[idx] = nib_sum;
`ifdef INC_EARLY_EXIT_EN
    for (int j = 0; j < NIBBLES; j++) begin
      if (j > int'(idx)) result_nxt[j] = operand_q[j];
    end
`endif
  end

  assign out_data = result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      operand_q <= '0;
      result_q  <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_cout  <= 1'b0;
      busy      <= 1'b0;
      ovf_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            operand_q <= in_data;
            carry     <= in_inc;
            idx       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          result_q <= result_nxt;
          carry    <= nib_cout;
          idx      <= idx + IDX_W'(1);
          if (done) begin
            out_cout  <= nib_cout;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (out_cout) ovf_count <= sat_inc(ovf_count);
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inc_nibble_sequencer.sv
// Directed bench for inc_nibble_sequencer with NIBBLES=2; expected values are hand-computed.
module tb_inc_nibble_sequencer;
  import inc_seq_pkg::*;

`ifdef INC_EARLY_EXIT_EN
  localparam int L_EARLY = 1;
`else
  localparam int L_EARLY = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_inc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_cout;
  logic       busy;
  logic [7:0] ovf_count;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_ovf  = 0;

  always #5 clk = ~clk;

  inc_nibble_sequencer #(.NIBBLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inc    (in_inc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cout  (out_cout),
    .busy      (busy),
    .ovf_count (ovf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] d, input logic inc, input logic [7:0] ed,
                        input logic ec, input int elat, input int hold);
    int lat;
    chk("pre_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_inc   = inc;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    in_inc   = ~inc;
    chk("run_busy", busy, 1);
    chk("run_in_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", lat, elat);
    chk("out_data", out_data, ed);
    chk("out_cout", out_cout, ec);
    chk("hold_in_ready", in_ready, 0);
    chk("hold_busy", busy, 1);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, ed);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (ec && exp_ovf != 255) exp_ovf++;
    chk("acc_out_valid", out_valid, 0);
    chk("acc_in_ready", in_ready, 1);
    chk("acc_busy", busy, 0);
    chk("acc_ovf", ovf_count, exp_ovf);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_inc    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_count, 0);

    run_op(8'h3A, 1'b1, 8'h3B, 1'b0, L_EARLY, 0);
    run_op(8'h0F, 1'b1, 8'h10, 1'b0, 2, 0);
    run_op(8'hFF, 1'b1, 8'h00, 1'b1, 2, 0);
    chk("ovf_after_ff", ovf_count, 1);
    run_op(8'h5C, 1'b0, 8'h5C, 1'b0, L_EARLY, 5);

    // Reset lands while the FF operand is mid-RUN.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_inc   = 1'b1;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    exp_ovf  = 0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_cout", out_cout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", ovf_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (3) tick();
    chk("mid_rst_no_result", out_valid, 0);

    run_op(8'h01, 1'b1, 8'h02, 1'b0, L_EARLY, 0);

    for (int i = 0; i < 256; i++) begin
      run_op(8'hFF, 1'b1, 8'h00, 1'b1, 2, 0);
    end
    chk("ovf_saturated", ovf_count, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
